// File: rtl/lut_wvf_gen_mch_pkg.sv
// Shared types and helpers for the multi-channel LUT waveform generator.
// Holds the control states, quadrant codes and quarter-wave mapping.
package lut_wvf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    Q0_RISE_POS = 2'd0,
    Q1_FALL_POS = 2'd1,
    Q2_FALL_NEG = 2'd2,
    Q3_RISE_NEG = 2'd3
  } quad_e;

  // Quadrants 1 and 3 walk the stored quarter backwards.
  function automatic logic quad_mirror(input quad_e q);
    return (q == Q1_FALL_POS) || (q == Q3_RISE_NEG);
  endfunction

  // Offset-binary reconstruction: midscale plus or minus the magnitude.
  function automatic logic [31:0] quarter_map(
    input quad_e       q,
    input logic [31:0] entry,
    input int          lut_bits
  );
    logic [31:0] m;
    logic [31:0] v;
    m = 32'd1 << (lut_bits - 1);
    v = entry & (m - 32'd1);
    if ((q == Q0_RISE_POS) || (q == Q1_FALL_POS))
      quarter_map = m + v;
    else
      quarter_map = m - v;
  endfunction

endpackage

// File: rtl/lut_wvf_gen_mch_phase_ch.sv
// One generator channel: phase accumulator, LUT select, quarter-wave
// mapping and registered sample / end-of-period outputs.
module lut_wvf_phase_ch
  import lut_wvf_pkg::*;
#(
  parameter int LUT_BITS   = 8,
  parameter int ADDR_BITS  = 4,
  parameter int PHASE_BITS = 8,
  parameter int LUT_DEPTH  = 2 ** ADDR_BITS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic                          tick_i,
  input  logic                          mode_quarter_i,
  input  logic [PHASE_BITS-1:0]         ofs_i,
  input  logic [PHASE_BITS-1:0]         inc_i,
  input  logic [LUT_DEPTH*LUT_BITS-1:0] lut_rom_i,
  output logic                          carry_o,
  output logic [LUT_BITS-1:0]           value_o,
  output logic                          end_o
);

  logic [PHASE_BITS-1:0] acc_q;
  logic [PHASE_BITS-1:0] acc_d;
  logic [PHASE_BITS:0]   sum;
  logic [LUT_BITS-1:0]   value_q;
  logic [LUT_BITS-1:0]   value_d;
  logic                  end_q;
  logic [ADDR_BITS-1:0]  faddr;
  logic [ADDR_BITS-1:0]  qidx;
  quad_e                 quad;

  assign sum     = {1'b0, acc_q} + {1'b0, inc_i};
  assign acc_d   = sum[PHASE_BITS-1:0];
  assign carry_o = sum[PHASE_BITS];
  assign value_o = value_q;
  assign end_o   = end_q;

  // Sample selection from the pre-increment phase.
  always_comb begin
    faddr = acc_q[PHASE_BITS-1 -: ADDR_BITS];
    quad  = quad_e'(acc_q[PHASE_BITS-1 -: 2]);
    qidx  = acc_q[PHASE_BITS-3 -: ADDR_BITS];
    if (quad_mirror(quad))
      qidx = ~qidx;
    if (mode_quarter_i)
      value_d = LUT_BITS'(quarter_map(
        quad,
        32'(lut_rom_i[qidx*LUT_BITS +: LUT_BITS]),
        LUT_BITS));
    else
      value_d = lut_rom_i[faddr*LUT_BITS +: LUT_BITS];
  end

  // Accumulator load/advance and registered sample outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      value_q <= '0;
      end_q   <= 1'b0;
    end else begin
      end_q <= 1'b0;
      if (load_i) begin
        acc_q <= ofs_i;
      end else if (tick_i) begin
        acc_q   <= acc_d;
        value_q <= value_d;
        end_q   <= carry_o;
      end
    end
  end

endmodule

// File: rtl/lut_wvf_gen_mch.sv
// Multi-channel DDS-style LUT waveform generator top: run control,
// sample pacing (wait counter or external trigger) and channel array.
module lut_wvf_gen_mch
  import lut_wvf_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int LUT_BITS   = 8,
  parameter int ADDR_BITS  = 4,
  parameter int PHASE_BITS = 8,
  parameter int WAIT_BITS  = 16
) (
  input  logic                                 CLK_SYS,
  input  logic                                 RST,
  input  logic                                 EN,
  input  logic                                 MODE_QUARTER,
  input  logic                                 ONE_SHOT,
  input  logic                                 TRGG_EXT_EN,
  input  logic                                 TRGG_CNT_FLAG,
  input  logic [WAIT_BITS-1:0]                 WAIT_CYC,
  input  logic [NUM_CH*PHASE_BITS-1:0]         PHASE_INC,
  input  logic [NUM_CH*PHASE_BITS-1:0]         PHASE_OFS,
  input  logic [(2**ADDR_BITS)*LUT_BITS-1:0]   LUT_ROM,
  output logic [NUM_CH*LUT_BITS-1:0]           LUT_VALUE,
  output logic                                 LUT_VALID,
  output logic [NUM_CH-1:0]                    LUT_END,
  output logic                                 BUSY
);

  state_e               state_q;
  logic [WAIT_BITS-1:0] cnt_q;
  logic                 trg_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 load;
  logic                 tick;
  logic [NUM_CH-1:0]    carry;
  logic                 unused_carry;

  assign load         = (state_q == ST_IDLE) && EN;
  assign LUT_VALID    = valid_q;
  assign BUSY         = busy_q;
  assign unused_carry = ^carry;

  // Sample strobe: only while running and enabled.
  always_comb begin
    tick = 1'b0;
    if ((state_q == ST_RUN) && EN) begin
      if (TRGG_EXT_EN)
        tick = TRGG_CNT_FLAG && !trg_q;
      else
        tick = (cnt_q >= WAIT_CYC);
    end
  end

  // Run-control FSM with wait counter, trigger history and flags.
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      trg_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      trg_q   <= TRGG_CNT_FLAG;
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (EN) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!EN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (cnt_q >= WAIT_CYC)
              cnt_q <= '0;
            else
              cnt_q <= cnt_q + 1'b1;
            if (tick) begin
              valid_q <= 1'b1;
              if (ONE_SHOT && carry[0]) begin
                state_q <= ST_HOLD;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!EN)
            state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lut_wvf_phase_ch #(
      .LUT_BITS  (LUT_BITS),
      .ADDR_BITS (ADDR_BITS),
      .PHASE_BITS(PHASE_BITS)
    ) u_ch (
      .clk_i         (CLK_SYS),
      .rst_i         (RST),
      .load_i        (load),
      .tick_i        (tick),
      .mode_quarter_i(MODE_QUARTER),
      .ofs_i         (PHASE_OFS[c*PHASE_BITS +: PHASE_BITS]),
      .inc_i         (PHASE_INC[c*PHASE_BITS +: PHASE_BITS]),
      .lut_rom_i     (LUT_ROM),
      .carry_o       (carry[c]),
      .value_o       (LUT_VALUE[c*LUT_BITS +: LUT_BITS]),
      .end_o         (LUT_END[c])
    );
  end

endmodule

// File: tb/tb_lut_wvf_gen_mch.sv
// Directed bench for lut_wvf_gen_mch with an expected-sample queue.
// Two channels, 8-bit phase, 16-entry 8-bit LUT.
module tb_lut_wvf_gen_mch;

  localparam int NUM_CH     = 2;
  localparam int LUT_BITS   = 8;
  localparam int ADDR_BITS  = 4;
  localparam int PHASE_BITS = 8;
  localparam int WAIT_BITS  = 16;

  logic         clk = 1'b0;
  logic         RST;
  logic         EN;
  logic         MODE_QUARTER;
  logic         ONE_SHOT;
  logic         TRGG_EXT_EN;
  logic         TRGG_CNT_FLAG;
  logic [15:0]  WAIT_CYC;
  logic [15:0]  PHASE_INC;
  logic [15:0]  PHASE_OFS;
  logic [127:0] LUT_ROM;
  logic [15:0]  LUT_VALUE;
  logic         LUT_VALID;
  logic [1:0]   LUT_END;
  logic         BUSY;

  always #5 clk = ~clk;

  lut_wvf_gen_mch #(
    .NUM_CH    (NUM_CH),
    .LUT_BITS  (LUT_BITS),
    .ADDR_BITS (ADDR_BITS),
    .PHASE_BITS(PHASE_BITS),
    .WAIT_BITS (WAIT_BITS)
  ) dut (
    .CLK_SYS      (clk),
    .RST          (RST),
    .EN           (EN),
    .MODE_QUARTER (MODE_QUARTER),
    .ONE_SHOT     (ONE_SHOT),
    .TRGG_EXT_EN  (TRGG_EXT_EN),
    .TRGG_CNT_FLAG(TRGG_CNT_FLAG),
    .WAIT_CYC     (WAIT_CYC),
    .PHASE_INC    (PHASE_INC),
    .PHASE_OFS    (PHASE_OFS),
    .LUT_ROM      (LUT_ROM),
    .LUT_VALUE    (LUT_VALUE),
    .LUT_VALID    (LUT_VALID),
    .LUT_END      (LUT_END),
    .BUSY         (BUSY)
  );

  typedef struct packed {
    logic [15:0] v;
    logic [1:0]  e;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   nvalid = 0;
  int   last_vc = -1;
  int   gap    = 0;
  int   base;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    if (LUT_VALID === 1'b1) begin
      nvalid++;
      if (gap != 0 && last_vc >= 0)
        chk("gap", cyc - last_vc, gap);
      last_vc = cyc;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("value", {16'd0, LUT_VALUE}, {16'd0, x.v});
        chk("end", {30'd0, LUT_END}, {30'd0, x.e});
      end
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic quiet(input string tag, input int n);
    int b = nvalid;
    repeat (n) step();
    chk(tag, nvalid - b, 0);
  endtask

  task automatic push(input logic [7:0] v0, input logic [7:0] v1,
                      input logic e0, input logic e1);
    exp_t x;
    x.v = {v1, v0};
    x.e = {e1, e0};
    exp_q.push_back(x);
  endtask

  // Full-wave LUT[i]=16*i, INC ch0=16 ch1=32, ch0 offset 0.
  task automatic push_full(input int k, input int ofs1);
    push(8'(16 * k), 8'(ofs1 + 32 * k),
         (k % 16) == 15, ((ofs1 / 32 + k) % 8) == 7);
  endtask

  task automatic set_lut(input int mul);
    for (int i = 0; i < 16; i++)
      LUT_ROM[i*8 +: 8] = 8'(mul * i);
  endtask

  initial begin
    int q;
    int i;
    logic [7:0] v0;
    RST = 1'b1; EN = 1'b0; MODE_QUARTER = 1'b0; ONE_SHOT = 1'b0;
    TRGG_EXT_EN = 1'b0; TRGG_CNT_FLAG = 1'b0; WAIT_CYC = 16'd3;
    PHASE_INC = {8'd32, 8'd16}; PHASE_OFS = 16'd0;
    LUT_ROM = '0;
    set_lut(16);
    repeat (3) step();
    chk("rst_value", {16'd0, LUT_VALUE}, 0);
    chk("rst_valid", {31'd0, LUT_VALID}, 0);
    chk("rst_end", {30'd0, LUT_END}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    RST = 1'b0;
    quiet("idle_no_valid", 4);

    // Full-wave, wait 3: a sample every 4 cycles, two ch0 periods.
    gap = 4; last_vc = -1;
    for (int k = 0; k < 32; k++) push_full(k, 0);
    EN = 1'b1;
    drain(200);
    chk("t1_busy", {31'd0, BUSY}, 1);
    EN = 1'b0;
    quiet("t1_stop", 6);
    chk("t1_busy_off", {31'd0, BUSY}, 0);

    // Quarter-wave, LUT[i]=8*i, ch0 INC=4 (64 samples), ch1 INC=0.
    MODE_QUARTER = 1'b1; WAIT_CYC = 16'd0;
    set_lut(8);
    PHASE_INC = {8'd0, 8'd4};
    gap = 1; last_vc = -1;
    for (int k = 0; k < 66; k++) begin
      q = (k % 64) / 16;
      i = k % 16;
      case (q)
        0:       v0 = 8'(128 + 8 * i);
        1:       v0 = 8'(248 - 8 * i);
        2:       v0 = 8'(128 - 8 * i);
        default: v0 = 8'(8 + 8 * i);
      endcase
      push(v0, 8'd128, (k % 64) == 63, 1'b0);
    end
    EN = 1'b1;
    drain(200);
    EN = 1'b0;
    quiet("t2_stop", 4);

    // Two channels every cycle, ch1 starts half a period in.
    MODE_QUARTER = 1'b0;
    set_lut(16);
    PHASE_INC = {8'd32, 8'd16};
    PHASE_OFS = {8'd128, 8'd0};
    gap = 1; last_vc = -1;
    for (int k = 0; k < 32; k++) push_full(k, 128);
    EN = 1'b1;
    drain(100);
    EN = 1'b0;
    quiet("t3_stop", 4);

    // One-shot: exactly one ch0 period, then hold.
    PHASE_OFS = 16'd0; WAIT_CYC = 16'd3; ONE_SHOT = 1'b1;
    gap = 4; last_vc = -1;
    for (int k = 0; k < 16; k++) push_full(k, 0);
    EN = 1'b1;
    drain(200);
    chk("t4_busy_fall", {31'd0, BUSY}, 0);
    quiet("t4_no_more", 30);
    chk("t4_hold_value", {16'd0, LUT_VALUE}, {16'd0, 8'd224, 8'd240});
    chk("t4_hold_busy", {31'd0, BUSY}, 0);
    EN = 1'b0;
    step(); step();
    last_vc = -1;
    for (int k = 0; k < 3; k++) push_full(k, 0);
    EN = 1'b1;
    drain(60);
    chk("t4_restart_busy", {31'd0, BUSY}, 1);
    EN = 1'b0;
    quiet("t4_stop", 4);
    ONE_SHOT = 1'b0;

    // External trigger pacing.
    TRGG_EXT_EN = 1'b1; WAIT_CYC = 16'd0; gap = 0; last_vc = -1;
    for (int k = 0; k < 3; k++) push_full(k, 0);
    EN = 1'b1;
    step(); step();
    base = nvalid;
    repeat (3) begin
      TRGG_CNT_FLAG = 1'b1;
      step(); step();
      TRGG_CNT_FLAG = 1'b0;
      repeat (3) step();
    end
    chk("t5_pulses", nvalid - base, 3);
    chk("t5_pulse_q", exp_q.size(), 0);
    push_full(3, 0);
    base = nvalid;
    TRGG_CNT_FLAG = 1'b1;
    repeat (20) step();
    TRGG_CNT_FLAG = 1'b0;
    step(); step();
    chk("t5_held", nvalid - base, 1);
    chk("t5_held_q", exp_q.size(), 0);
    quiet("t5_no_flag", 15);
    EN = 1'b0;
    step();
    TRGG_EXT_EN = 1'b0;

    // EN drop and reset on tick cycles mid-run.
    gap = 1; last_vc = -1;
    for (int k = 0; k < 4; k++) push_full(k, 0);
    EN = 1'b1;
    drain(40);
    EN = 1'b0;
    step();
    chk("t6_en0_valid", {31'd0, LUT_VALID}, 0);
    chk("t6_en0_busy", {31'd0, BUSY}, 0);
    last_vc = -1;
    for (int k = 0; k < 4; k++) push_full(k, 0);
    EN = 1'b1;
    drain(40);
    RST = 1'b1;
    step();
    chk("t6_rst_valid", {31'd0, LUT_VALID}, 0);
    chk("t6_rst_value", {16'd0, LUT_VALUE}, 0);
    chk("t6_rst_end", {30'd0, LUT_END}, 0);
    chk("t6_rst_busy", {31'd0, BUSY}, 0);
    RST = 1'b0; EN = 1'b0;
    quiet("t6_after_rst", 3);
    chk("t6_idle_busy", {31'd0, BUSY}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
